// File: rtl/rbcp_reg_slave.sv
// RBCP register slave: 16-byte window with control word, status, soft-reset pulse,
// saturating event counter with read snapshot, and a device ID byte.
module rbcp_reg_slave #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter logic [7:0]  SOFT_RST_LEN = 8'd16,
   parameter logic [7:0]  DEVICE_ID    = 8'hA5
) (
   input  logic        CLK,
   input  logic        SYS_RSTn,
   input  logic [31:0] RBCP_ADDR,
   input  logic [7:0]  RBCP_WD,
   input  logic        RBCP_WE,
   input  logic        RBCP_RE,
   output logic        RBCP_ACK,
   output logic [7:0]  RBCP_RD,
   input  logic [7:0]  STATUS_IN,
   input  logic        EVT_IN,
   output logic [31:0] CTRL_OUT,
   output logic        SOFT_RESET
);

   typedef enum logic {IDLE, ACK} state_t;

   state_t      state;
   logic [7:0]  sr_cnt;
   logic [31:0] evt_cnt;
   logic [31:0] snap;
   logic [3:0]  offset;
   logic        hit;
   logic        accept;
   logic        wr;
   logic        rd;
   logic        evt_clr;
   logic        sr_start;
   logic [7:0]  read_byte;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign offset   = RBCP_ADDR[3:0];
   assign hit      = (RBCP_ADDR[31:4] == BASE_ADDR[31:4]);
   // Strobes during the ACK cycle are dropped; WE wins over RE when both are high.
   assign accept   = (state == IDLE) && hit && (RBCP_WE || RBCP_RE);
   assign wr       = accept && RBCP_WE;
   assign rd       = accept && !RBCP_WE;
   assign evt_clr  = wr && (offset == 4'h5) && RBCP_WD[1];
   assign sr_start = wr && (offset == 4'h5) && RBCP_WD[0];

   assign SOFT_RESET = (sr_cnt != 8'd0);

   // Offset 0x8 returns the live counter MSB because the snapshot is loaded on this same edge.
   always_comb begin
      read_byte = 8'h00;
      case (offset)
         4'h0:    read_byte = CTRL_OUT[31:24];
         4'h1:    read_byte = CTRL_OUT[23:16];
         4'h2:    read_byte = CTRL_OUT[15:8];
         4'h3:    read_byte = CTRL_OUT[7:0];
         4'h4:    read_byte = STATUS_IN;
         4'h5:    read_byte = {7'b0, SOFT_RESET};
         4'h8:    read_byte = evt_cnt[31:24];
         4'h9:    read_byte = snap[23:16];
         4'hA:    read_byte = snap[15:8];
         4'hB:    read_byte = snap[7:0];
         4'hF:    read_byte = DEVICE_ID;
         default: read_byte = 8'h00;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!SYS_RSTn) begin
         state    <= IDLE;
         RBCP_ACK <= 1'b0;
         RBCP_RD  <= 8'h00;
         CTRL_OUT <= 32'h0;
         sr_cnt   <= 8'd0;
         evt_cnt  <= 32'h0;
         snap     <= 32'h0;
      end else begin
         state    <= accept ? ACK : IDLE;
         RBCP_ACK <= accept;
         RBCP_RD  <= rd ? read_byte : 8'h00;

         if (wr) begin
            case (offset)
               4'h0:    CTRL_OUT[31:24] <= RBCP_WD;
               4'h1:    CTRL_OUT[23:16] <= RBCP_WD;
               4'h2:    CTRL_OUT[15:8]  <= RBCP_WD;
               4'h3:    CTRL_OUT[7:0]   <= RBCP_WD;
               default: ;
            endcase
         end

         if (rd && (offset == 4'h8))
            snap <= evt_cnt;

         if (evt_clr)
            evt_cnt <= 32'h0;
         else if (EVT_IN)
            evt_cnt <= sat_inc(evt_cnt);

         // Loading the full length on a retrigger restarts the pulse from the new ACK cycle.
         if (sr_start)
            sr_cnt <= SOFT_RST_LEN;
         else if (sr_cnt != 8'd0)
            sr_cnt <= sr_cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Directed bench for rbcp_reg_slave: linear stimulus, immediate-assertion checks.
module tb_rbcp_reg_slave;

   localparam logic [31:0] BASE = 32'h4000_1230;

   logic        CLK = 1'b0;
   logic        SYS_RSTn;
   logic [31:0] RBCP_ADDR;
   logic [7:0]  RBCP_WD;
   logic        RBCP_WE;
   logic        RBCP_RE;
   logic        RBCP_ACK;
   logic [7:0]  RBCP_RD;
   logic [7:0]  STATUS_IN;
   logic        EVT_IN;
   logic [31:0] CTRL_OUT;
   logic        SOFT_RESET;

   int n_asserts = 0;
   int n_fail    = 0;
   int n;

   rbcp_reg_slave #(
      .BASE_ADDR   (BASE),
      .SOFT_RST_LEN(8'd16),
      .DEVICE_ID   (8'hA5)
   ) dut (
      .CLK       (CLK),
      .SYS_RSTn  (SYS_RSTn),
      .RBCP_ADDR (RBCP_ADDR),
      .RBCP_WD   (RBCP_WD),
      .RBCP_WE   (RBCP_WE),
      .RBCP_RE   (RBCP_RE),
      .RBCP_ACK  (RBCP_ACK),
      .RBCP_RD   (RBCP_RD),
      .STATUS_IN (STATUS_IN),
      .EVT_IN    (EVT_IN),
      .CTRL_OUT  (CTRL_OUT),
      .SOFT_RESET(SOFT_RESET)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One read access: strobe for one edge, check the ACK cycle, then idle one cycle.
   task automatic do_read(input logic [3:0] off, input logic [7:0] exp, input string tag);
      RBCP_ADDR = BASE + {28'h0, off};
      RBCP_RE   = 1'b1;
      tick();
      RBCP_RE   = 1'b0;
      check({tag, "_ack"}, {31'b0, RBCP_ACK}, 32'd1);
      check({tag, "_rd"}, {24'b0, RBCP_RD}, {24'b0, exp});
      tick();
   endtask

   task automatic do_write(input logic [3:0] off, input logic [7:0] wd);
      RBCP_ADDR = BASE + {28'h0, off};
      RBCP_WD   = wd;
      RBCP_WE   = 1'b1;
      tick();
      RBCP_WE   = 1'b0;
   endtask

   initial begin
      SYS_RSTn  = 1'b0;
      RBCP_ADDR = 32'h0;
      RBCP_WD   = 8'h00;
      RBCP_WE   = 1'b0;
      RBCP_RE   = 1'b0;
      STATUS_IN = 8'h00;
      EVT_IN    = 1'b0;
      tick();
      tick();
      check("rst_ack", {31'b0, RBCP_ACK}, 32'd0);
      check("rst_rd", {24'b0, RBCP_RD}, 32'd0);
      check("rst_ctrl", CTRL_OUT, 32'h0);
      check("rst_srst", {31'b0, SOFT_RESET}, 32'd0);

      // First strobe on the first edge with reset released
      SYS_RSTn  = 1'b1;
      RBCP_ADDR = BASE + 32'h2;
      RBCP_WD   = 8'h5A;
      RBCP_WE   = 1'b1;
      tick();
      RBCP_WE   = 1'b0;
      check("wr2_ack", {31'b0, RBCP_ACK}, 32'd1);
      check("wr2_rd", {24'b0, RBCP_RD}, 32'd0);
      check("wr2_ctrl", CTRL_OUT, 32'h0000_5A00);
      tick();
      check("wr2_ack_end", {31'b0, RBCP_ACK}, 32'd0);
      do_read(4'h2, 8'h5A, "rd2");
      check("idle_rd", {24'b0, RBCP_RD}, 32'd0);

      // Out-of-window strobes: no ACK, no register effect
      RBCP_ADDR = BASE + 32'h10;
      RBCP_RE   = 1'b1;
      tick();
      RBCP_ADDR = 32'hFFFF_FF3C;
      tick();
      RBCP_RE   = 1'b0;
      RBCP_WE   = 1'b1;
      RBCP_ADDR = BASE + 32'h12;
      RBCP_WD   = 8'h77;
      tick();
      RBCP_WE   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("miss_ack", {31'b0, RBCP_ACK}, 32'd0);
         check("miss_rd", {24'b0, RBCP_RD}, 32'd0);
         tick();
      end
      check("miss_ctrl", CTRL_OUT, 32'h0000_5A00);

      // Status, device ID, unused offsets
      STATUS_IN = 8'hC3;
      do_read(4'h4, 8'hC3, "status");
      do_read(4'hF, 8'hA5, "devid");
      do_write(4'hF, 8'h11);
      tick();
      do_read(4'hF, 8'hA5, "devid_wr");
      do_write(4'hC, 8'h33);
      tick();
      do_read(4'hC, 8'h00, "unused_c");
      do_read(4'h6, 8'h00, "unused_6");

      // Event counter and snapshot
      EVT_IN = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      EVT_IN = 1'b0;
      do_read(4'h8, 8'h00, "evt_b3");
      do_read(4'h9, 8'h00, "evt_b2");
      do_read(4'hA, 8'h00, "evt_b1");
      do_read(4'hB, 8'h0A, "evt_b0");
      EVT_IN = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      EVT_IN = 1'b0;
      do_read(4'hB, 8'h0A, "evt_norelatch");
      do_read(4'h8, 8'h00, "evt_relatch_b3");
      do_read(4'hB, 8'h0F, "evt_relatch_b0");
      EVT_IN = 1'b1;
      do_write(4'h5, 8'h02);
      EVT_IN = 1'b0;
      check("clr_srst", {31'b0, SOFT_RESET}, 32'd0);
      tick();
      do_read(4'h8, 8'h00, "clr_b3");
      do_read(4'hB, 8'h00, "clr_b0");

      // Soft reset pulse length
      do_write(4'h5, 8'h01);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (SOFT_RESET) n++;
         tick();
      end
      check("srst_len", n, 32'd16);

      // Retrigger at pulse cycle 10 extends to 26 cycles
      do_write(4'h5, 8'h01);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         if (SOFT_RESET) n++;
         if (i == 9) begin
            RBCP_ADDR = BASE + 32'h5;
            RBCP_WD   = 8'h01;
            RBCP_WE   = 1'b1;
         end else begin
            RBCP_WE   = 1'b0;
         end
         tick();
      end
      RBCP_WE = 1'b0;
      check("srst_retrig_len", n, 32'd26);

      // Soft reset status readback
      do_write(4'h5, 8'h01);
      tick();
      do_read(4'h5, 8'h01, "srst_rd_on");
      for (int i = 0; i < 20; i++) tick();
      do_read(4'h5, 8'h00, "srst_rd_off");

      // Back-to-back reads: second strobe lands in the ACK cycle
      RBCP_ADDR = BASE + 32'h2;
      RBCP_RE   = 1'b1;
      tick();
      check("b2b_ack1", {31'b0, RBCP_ACK}, 32'd1);
      tick();
      RBCP_RE   = 1'b0;
      check("b2b_ack2", {31'b0, RBCP_ACK}, 32'd0);
      tick();
      check("b2b_ack3", {31'b0, RBCP_ACK}, 32'd0);

      // WE and RE together act as a write
      RBCP_ADDR = BASE;
      RBCP_WD   = 8'hFF;
      RBCP_WE   = 1'b1;
      RBCP_RE   = 1'b1;
      tick();
      RBCP_WE   = 1'b0;
      RBCP_RE   = 1'b0;
      check("wer_ack", {31'b0, RBCP_ACK}, 32'd1);
      check("wer_rd", {24'b0, RBCP_RD}, 32'd0);
      check("wer_ctrl", CTRL_OUT, 32'hFF00_5A00);
      tick();
      check("wer_ack_end", {31'b0, RBCP_ACK}, 32'd0);

      // Reset coinciding with a strobe, with state built up beforehand
      EVT_IN = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      EVT_IN = 1'b0;
      do_write(4'h5, 8'h01);
      check("pre_rst_srst", {31'b0, SOFT_RESET}, 32'd1);
      tick();
      SYS_RSTn  = 1'b0;
      RBCP_ADDR = BASE + 32'h2;
      RBCP_RE   = 1'b1;
      tick();
      SYS_RSTn  = 1'b1;
      RBCP_RE   = 1'b0;
      check("mid_rst_ack", {31'b0, RBCP_ACK}, 32'd0);
      check("mid_rst_rd", {24'b0, RBCP_RD}, 32'd0);
      check("mid_rst_ctrl", CTRL_OUT, 32'h0);
      check("mid_rst_srst", {31'b0, SOFT_RESET}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_ack", {31'b0, RBCP_ACK}, 32'd0);
      end
      do_read(4'h8, 8'h00, "post_rst_b3");
      do_read(4'hB, 8'h00, "post_rst_b0");
      do_read(4'h0, 8'h00, "post_rst_ctrl0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/rbcp_reg_slave.md
RBCP_REG_SLAVE -- requirements
Module: rbcp_reg_slave

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, RBCP window base; SHALL be 16-byte aligned (bits [3:0] = 0).
REQ-002 Parameter SOFT_RST_LEN, 8'd16, SOFT_RESET pulse length in CLK cycles, 1..255.
REQ-003 Parameter DEVICE_ID, 8'hA5, constant returned at offset 0xF.
REQ-004 CLK  in  1  system clock; sole clock, all logic on rising edge.
REQ-005 SYS_RSTn  in  1  one clock; reset is synchronous and active-low.
REQ-006 RBCP_ADDR  in  32  access address, valid while RBCP_WE or RBCP_RE high.
REQ-007 RBCP_WD  in  8  write data, valid with RBCP_WE.
REQ-008 RBCP_WE  in  1  single-cycle write strobe.
REQ-009 RBCP_RE  in  1  single-cycle read strobe.
REQ-010 RBCP_ACK  out  1  single-cycle access acknowledge.
REQ-011 RBCP_RD  out  8  read data, valid only while RBCP_ACK high.
REQ-012 STATUS_IN  in  8  user status byte, read-only at offset 0x4.
REQ-013 EVT_IN  in  1  event strobe; each high cycle increments the event counter.
REQ-014 CTRL_OUT  out  32  control word from offsets 0x0-0x3.
REQ-015 SOFT_RESET  out  1  active-high reset pulse to user logic.

Function
REQ-016 Window hit SHALL be RBCP_ADDR[31:4] == BASE_ADDR[31:4]; offset = RBCP_ADDR[3:0].
REQ-017 FSM SHALL have states IDLE and ACK; IDLE->ACK on (RBCP_WE|RBCP_RE) & hit; ACK->IDLE unconditionally after one cycle.
REQ-018 Strobe sampled at edge N SHALL produce RBCP_ACK=1 for exactly cycle N+1; RBCP_RD valid in that same cycle.
REQ-019 RBCP_RD SHALL be 8'h00 whenever RBCP_ACK is 0 and for every write acknowledge.
REQ-020 Strobes with no window hit SHALL produce no ACK and no state change.
REQ-021 Strobes arriving while in ACK state SHALL be ignored (no second ACK, no register effect).
REQ-022 RBCP_WE and RBCP_RE high together SHALL be handled as a write only; one ACK.
REQ-023 Offsets 0x0-0x3 R/W; offset k maps to CTRL_OUT[31-8k -: 8] (0x0 = MSB); write updates CTRL_OUT at the ACK cycle.
REQ-024 Offset 0x4 SHALL read STATUS_IN sampled at strobe edge; writes acked and discarded.
REQ-025 Offset 0x5 write: WD[0]=1 starts SOFT_RESET for SOFT_RST_LEN cycles beginning at the ACK cycle; WD[1]=1 clears event counter to 0.
REQ-026 Write to 0x5 with WD[0]=1 while SOFT_RESET active SHALL restart the full SOFT_RST_LEN count.
REQ-027 Offset 0x5 read SHALL return {7'b0, SOFT_RESET}.
REQ-028 Event counter SHALL be 32-bit, increment per EVT_IN cycle, saturate at 32'hFFFF_FFFF.
REQ-029 Counter clear and EVT_IN in the same cycle SHALL yield 0.
REQ-030 Read of 0x8 SHALL latch counter into a 32-bit snapshot at the strobe edge and return snapshot[31:24]; reads of 0x9/0xA/0xB return snapshot[23:16]/[15:8]/[7:0] without relatching.
REQ-031 Offset 0xF SHALL read DEVICE_ID; writes discarded.
REQ-032 Other offsets (0x6,0x7,0xC-0xE) SHALL read 8'h00, writes discarded, still acked.

Reset
REQ-033 SYS_RSTn low at an edge SHALL force state IDLE, RBCP_ACK=0, RBCP_RD=0, CTRL_OUT=0, SOFT_RESET=0, counter=0, snapshot=0, SOFT_RESET count=0.
REQ-034 Reset asserted mid-access SHALL cancel the pending ACK; no ACK after release without a new strobe.
REQ-035 First strobe SHALL be accepted at the first edge with SYS_RSTn high.

Verification
REQ-036 WE addr BASE+0x2 WD=8'h5A -> ACK one cycle later for 1 cycle, CTRL_OUT=32'h00005A00; read BASE+0x2 -> RD=8'h5A with ACK.
REQ-037 RE addr BASE+0x10 or 0xFFFF_FF3C -> no ACK for 8 cycles, RD stays 8'h00.
REQ-038 10 EVT_IN pulses, read 0x8..0xB -> 8'h00,00,00,0A; 5 more pulses then read 0xB -> still 8'h0A; write 0x5 WD=8'h02 with EVT_IN high -> counter 0.
REQ-039 Write 0x5 WD=8'h01 -> SOFT_RESET high exactly 16 cycles; rewrite at cycle 10 -> high 26 cycles total.
REQ-040 Back-to-back RE on consecutive cycles -> single ACK; WE+RE together at BASE+0x0 WD=8'hFF -> one ACK, RD=8'h00, CTRL_OUT[31:24]=8'hFF.
REQ-041 Strobe then SYS_RSTn low for 1 cycle at the next edge -> no ACK, all outputs at reset values.
